trigger_frame_decoder: RTL and testbench



---
 rtl/trigger_frame_decoder.sv | 246 ++++++++++++++++++++++++
 tb/tb_trigger_frame_decoder.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_frame_decoder.sv
// Rebuilds unbackpressured trigger bursts into header/data/footer AXI-Stream frames behind a FWFT FIFO.
// Define TRIGGER_DECODER_CHECKSUM_EN to place a lane-XOR checksum in footer bits [55:40].
module trigger_frame_decoder #(
  parameter int unsigned FIFO_DEPTH      = 512,
  parameter int unsigned MAX_FRAME_BEATS = 64,
  parameter logic [15:0] CHANNEL_ID      = 16'h0000
) (
  input  logic         ACLK,
  input  logic         ARESET,
  input  logic         SET_CONFIG,
  input  logic [215:0] S_AXIS_TDATA,
  input  logic         S_AXIS_TVALID,
  output logic [127:0] M_AXIS_TDATA,
  output logic         M_AXIS_TVALID,
  input  logic         M_AXIS_TREADY,
  output logic         M_AXIS_TLAST,
  output logic [31:0]  FRAME_COUNT,
  output logic [31:0]  DROP_COUNT
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StData, StGap, StDrop} state_e;

  logic [127:0] in_data;
  logic [7:0]   in_info;
  logic [47:0]  in_ts;
  logic [31:0]  in_cfg;

  assign in_data = S_AXIS_TDATA[215:88];
  assign in_info = S_AXIS_TDATA[87:80];
  assign in_ts   = S_AXIS_TDATA[79:32];
  assign in_cfg  = S_AXIS_TDATA[31:0];

  state_e       state_q, state_d;
  logic         hold_valid_q, hold_valid_d;
  logic [127:0] hold_data_q, hold_data_d;
  logic [15:0]  cnt_q, cnt_d;
  logic [7:0]   hdr_info_q, hdr_info_d;
  logic         trunc_q, trunc_d;
  logic         chg_q, chg_d;
  logic         merged_q, merged_d;
  logic         drop_idle_q, drop_idle_d;
  logic [31:0]  frame_cnt_q, frame_cnt_d;
  logic [31:0]  drop_cnt_q, drop_cnt_d;

  logic         wr_en;
  logic [128:0] wr_word;
  logic         hdr_wr;
  logic         load;
  logic         admit;
  logic [15:0]  csum_field;

  logic [128:0]    mem [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] fifo_cnt_q;
  logic            push, pop, empty;

  // Worst-case reservation: header + MAX_FRAME_BEATS data + footer.
  assign admit = (FIFO_DEPTH - 32'(fifo_cnt_q)) >= (MAX_FRAME_BEATS + 2);

  always_comb begin
    state_d      = state_q;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    cnt_d        = cnt_q;
    hdr_info_d   = hdr_info_q;
    trunc_d      = trunc_q;
    chg_d        = chg_q;
    merged_d     = merged_q;
    drop_idle_d  = drop_idle_q;
    frame_cnt_d  = frame_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    wr_en        = 1'b0;
    wr_word      = '0;
    hdr_wr       = 1'b0;
    load         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (S_AXIS_TVALID) begin
          if (admit) begin
            hdr_wr       = 1'b1;
            wr_en        = 1'b1;
            wr_word      = {1'b0, 16'hAA55, in_info, in_ts, in_cfg, CHANNEL_ID, 8'h00};
            hold_valid_d = 1'b1;
            hold_data_d  = in_data;
            cnt_d        = 16'd1;
            hdr_info_d   = in_info;
            trunc_d      = 1'b0;
            chg_d        = 1'b0;
            merged_d     = 1'b0;
            state_d      = StData;
          end else begin
            drop_cnt_d  = drop_cnt_q + 32'd1;
            drop_idle_d = 1'b0;
            state_d     = StDrop;
          end
        end
      end
      StData: begin
        if (S_AXIS_TVALID) begin
          if (32'(cnt_q) < MAX_FRAME_BEATS) begin
            wr_en   = hold_valid_q;
            wr_word = {1'b0, hold_data_q};
            load    = 1'b1;
          end else begin
            trunc_d = 1'b1;
          end
        end else begin
          wr_en        = hold_valid_q;
          wr_word      = {1'b0, hold_data_q};
          hold_valid_d = 1'b0;
          state_d      = StGap;
        end
      end
      StGap: begin
        if (S_AXIS_TVALID) begin
          merged_d = 1'b1;
          state_d  = StData;
          if (32'(cnt_q) < MAX_FRAME_BEATS) begin
            load = 1'b1;
          end else begin
            trunc_d = 1'b1;
          end
        end else begin
          wr_en       = 1'b1;
          wr_word     = {1'b1, 16'h55AA, cnt_q, frame_cnt_q,
                         5'b0, merged_q, chg_q, trunc_q, csum_field, 40'b0};
          frame_cnt_d = frame_cnt_q + 32'd1;
          state_d     = StIdle;
        end
      end
      StDrop: begin
        if (S_AXIS_TVALID) begin
          drop_idle_d = 1'b0;
        end else if (drop_idle_q) begin
          state_d = StIdle;
        end else begin
          drop_idle_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      hold_valid_d = 1'b1;
      hold_data_d  = in_data;
      cnt_d        = cnt_q + 16'd1;
      if (in_info != hdr_info_q) chg_d = 1'b1;
    end
  end

`ifdef TRIGGER_DECODER_CHECKSUM_EN
  function automatic logic [15:0] lane_xor(input logic [127:0] d);
    logic [15:0] x;
    x = '0;
    for (int i = 0; i < 8; i++) x ^= d[16*i +: 16];
    return x;
  endfunction

  logic [15:0] csum_q, csum_d;

  // Accumulated on hold load; the loaded set is exactly the set later written.
  always_comb begin
    csum_d = csum_q;
    if (hdr_wr) begin
      csum_d = lane_xor(in_data);
    end else if (load) begin
      csum_d = csum_q ^ lane_xor(in_data);
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET || SET_CONFIG) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign csum_field = csum_q;
`else
  assign csum_field = '0;
`endif

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q      <= StIdle;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      cnt_q        <= '0;
      hdr_info_q   <= '0;
      trunc_q      <= 1'b0;
      chg_q        <= 1'b0;
      merged_q     <= 1'b0;
      drop_idle_q  <= 1'b0;
      frame_cnt_q  <= '0;
      drop_cnt_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
    end else if (SET_CONFIG) begin
      state_q      <= StIdle;
      hold_valid_q <= 1'b0;
      cnt_q        <= '0;
      trunc_q      <= 1'b0;
      chg_q        <= 1'b0;
      merged_q     <= 1'b0;
      drop_idle_q  <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      cnt_q        <= cnt_d;
      hdr_info_q   <= hdr_info_d;
      trunc_q      <= trunc_d;
      chg_q        <= chg_d;
      merged_q     <= merged_d;
      drop_idle_q  <= drop_idle_d;
      frame_cnt_q  <= frame_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      fifo_cnt_q <= fifo_cnt_q + CntW'(push) - CntW'(pop);
    end
  end

  assign push  = wr_en && !ARESET && !SET_CONFIG;
  assign empty = (fifo_cnt_q == '0);
  assign pop   = M_AXIS_TVALID && M_AXIS_TREADY;

  always_ff @(posedge ACLK) begin
    if (push) mem[wr_ptr_q] <= wr_word;
  end

  assign M_AXIS_TVALID              = !empty;
  assign {M_AXIS_TLAST, M_AXIS_TDATA} = empty ? 129'b0 : mem[rd_ptr_q];
  assign FRAME_COUNT                = frame_cnt_q;
  assign DROP_COUNT                 = drop_cnt_q;

endmodule

// File: tb/tb_trigger_frame_decoder.sv
// Scoreboard bench for trigger_frame_decoder: burst-level reference model feeds an expected-beat
// queue that an independent output monitor drains and compares.
module tb_trigger_frame_decoder;

  localparam int unsigned Depth   = 128;
  localparam int unsigned MaxB    = 64;
  localparam logic [15:0] ChanId  = 16'h1234;

  logic         ACLK = 1'b0;
  logic         ARESET = 1'b1;
  logic         SET_CONFIG = 1'b0;
  logic [215:0] S_AXIS_TDATA = '0;
  logic         S_AXIS_TVALID = 1'b0;
  logic [127:0] M_AXIS_TDATA;
  logic         M_AXIS_TVALID;
  logic         M_AXIS_TREADY = 1'b0;
  logic         M_AXIS_TLAST;
  logic [31:0]  FRAME_COUNT;
  logic [31:0]  DROP_COUNT;

  trigger_frame_decoder #(
    .FIFO_DEPTH     (Depth),
    .MAX_FRAME_BEATS(MaxB),
    .CHANNEL_ID     (ChanId)
  ) dut (
    .ACLK         (ACLK),
    .ARESET       (ARESET),
    .SET_CONFIG   (SET_CONFIG),
    .S_AXIS_TDATA (S_AXIS_TDATA),
    .S_AXIS_TVALID(S_AXIS_TVALID),
    .M_AXIS_TDATA (M_AXIS_TDATA),
    .M_AXIS_TVALID(M_AXIS_TVALID),
    .M_AXIS_TREADY(M_AXIS_TREADY),
    .M_AXIS_TLAST (M_AXIS_TLAST),
    .FRAME_COUNT  (FRAME_COUNT),
    .DROP_COUNT   (DROP_COUNT)
  );

  always #5 ACLK = ~ACLK;

  int n_assert = 0;
  int n_fail = 0;
  int pops = 0;
  int model_frames = 0;
  int model_drops = 0;
  int ready_mode = 0;  // 0 low, 1 high, 2 random

  logic [215:0] beats[$];
  int           lens[$];
  logic [128:0] sb[$];

  task automatic check(input string name, input logic [129:0] act, input logic [129:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [215:0] mk_beat(input logic [127:0] d, input logic [7:0] inf,
                                           input logic [47:0] ts, input logic [31:0] cfg);
    return {d, inf, ts, cfg};
  endfunction

  // Frame content from the burst list: first MaxB beats survive, >1 burst means merged.
  task automatic push_frame();
    int          total, nload;
    logic [7:0]  info0, flags;
    logic        chg;
    logic [15:0] csum, exp_csum;
    total = beats.size();
    nload = (total > MaxB) ? MaxB : total;
    info0 = beats[0][87:80];
    chg   = 1'b0;
    csum  = '0;
    sb.push_back({1'b0, 16'hAA55, info0, beats[0][79:32], beats[0][31:0], ChanId, 8'h00});
    for (int i = 0; i < nload; i++) begin
      sb.push_back({1'b0, beats[i][215:88]});
      if (beats[i][87:80] != info0) chg = 1'b1;
      for (int l = 0; l < 8; l++) csum ^= beats[i][88 + 16*l +: 16];
    end
`ifdef TRIGGER_DECODER_CHECKSUM_EN
    exp_csum = csum;
`else
    exp_csum = 16'h0000;
`endif
    flags = {5'b0, lens.size() > 1, chg, total > MaxB};
    sb.push_back({1'b1, 16'h55AA, 16'(nload), 32'(model_frames), flags, exp_csum, 40'b0});
    model_frames++;
  endtask

  task automatic drive_frame();
    int k;
    k = 0;
    for (int b = 0; b < lens.size(); b++) begin
      for (int j = 0; j < lens[b]; j++) begin
        @(posedge ACLK); #1;
        S_AXIS_TVALID = 1'b1;
        S_AXIS_TDATA  = beats[k];
        k++;
      end
      if (b != lens.size() - 1) begin
        @(posedge ACLK); #1;
        S_AXIS_TVALID = 1'b0;
      end
    end
    repeat (2) begin
      @(posedge ACLK); #1;
      S_AXIS_TVALID = 1'b0;
    end
  endtask

  task automatic run_frame(input bit admitted);
    if (admitted) push_frame();
    else model_drops++;
    drive_frame();
  endtask

  task automatic wait_room(input int limit);
    int t;
    t = 0;
    while (sb.size() > limit && t < 5000) begin
      @(posedge ACLK);
      t++;
    end
    if (sb.size() > limit) begin
      n_assert++;
      n_fail++;
      $display("FAIL drain_timeout: outstanding %0d required <= %0d", sb.size(), limit);
    end
    repeat (2) @(posedge ACLK);
  endtask

  task automatic gen_random_frame();
    int         nb, len;
    logic [7:0] inf;
    logic [47:0] ts;
    beats.delete();
    lens.delete();
    nb  = $urandom_range(1, 3);
    inf = 8'($urandom);
    ts  = {16'($urandom), 32'($urandom)};
    for (int b = 0; b < nb; b++) begin
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(60, 72) : $urandom_range(1, 20);
      lens.push_back(len);
      for (int j = 0; j < len; j++) begin
        beats.push_back(mk_beat({$urandom, $urandom, $urandom, $urandom},
                                ($urandom_range(0, 9) == 0) ? 8'($urandom) : inf,
                                ts + 48'(beats.size()), $urandom));
      end
    end
  endtask

  task automatic simple_frame(input int len, input logic [7:0] inf);
    beats.delete();
    lens.delete();
    lens.push_back(len);
    for (int j = 0; j < len; j++)
      beats.push_back(mk_beat({$urandom, $urandom, $urandom, $urandom}, inf, 48'(1000 + j), 32'hC0DE));
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_frame_count"}, 130'(FRAME_COUNT), 130'(model_frames));
    check({tag, "_drop_count"}, 130'(DROP_COUNT), 130'(model_drops));
  endtask

  // Abort a frame after 10 beats with either flush source; nothing of it may reach the output.
  task automatic flush_mid_frame(input bit use_reset);
    wait_room(0);
    ready_mode = 0;
    repeat (2) @(posedge ACLK);
    for (int j = 0; j < 10; j++) begin
      @(posedge ACLK); #1;
      S_AXIS_TVALID = 1'b1;
      S_AXIS_TDATA  = mk_beat({4{$urandom}}, 8'h11, 48'(j), 32'h5);
    end
    @(posedge ACLK); #1;
    S_AXIS_TVALID = 1'b0;
    if (use_reset) ARESET = 1'b1;
    else SET_CONFIG = 1'b1;
    @(negedge ACLK);
    check("pre_flush_valid", 130'(M_AXIS_TVALID), 130'(1));
    @(posedge ACLK); #1;
    ARESET     = 1'b0;
    SET_CONFIG = 1'b0;
    if (use_reset) begin
      model_frames = 0;
      model_drops  = 0;
    end
    @(negedge ACLK);
    check("post_flush_valid", 130'({M_AXIS_TVALID, M_AXIS_TLAST}), 130'(0));
    check_counters(use_reset ? "after_reset" : "after_setcfg");
    ready_mode = 1;
    repeat (5) @(posedge ACLK);
    simple_frame(4, 8'h22);
    run_frame(1'b1);
    wait_room(0);
  endtask

  initial begin
    forever begin
      @(posedge ACLK); #1;
      case (ready_mode)
        0:       M_AXIS_TREADY = 1'b0;
        1:       M_AXIS_TREADY = 1'b1;
        default: M_AXIS_TREADY = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  logic         prev_stall = 1'b0;
  logic [128:0] prev_word = '0;
  logic [128:0] exp_word;

  always @(negedge ACLK) begin
    if (prev_stall)
      check("hold_stable", {M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA}, {1'b1, prev_word});
    if (M_AXIS_TVALID && M_AXIS_TREADY) begin
      pops++;
      if (sb.size() == 0) begin
        n_assert++;
        n_fail++;
        $display("FAIL unexpected_beat: actual %h required none", {M_AXIS_TLAST, M_AXIS_TDATA});
      end else begin
        exp_word = sb.pop_front();
        check("out_beat", {M_AXIS_TLAST, M_AXIS_TDATA}, exp_word);
      end
    end
    prev_stall = M_AXIS_TVALID && !M_AXIS_TREADY && !SET_CONFIG && !ARESET;
    prev_word  = {M_AXIS_TLAST, M_AXIS_TDATA};
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  int pops_before;

  initial begin
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check("reset_valid", 130'(M_AXIS_TVALID), 130'(0));
    check("reset_last", 130'(M_AXIS_TLAST), 130'(0));
    check("reset_data", 130'(M_AXIS_TDATA), 130'(0));
    check_counters("reset");
    @(posedge ACLK); #1;
    ARESET     = 1'b0;
    ready_mode = 1;
    repeat (3) @(posedge ACLK);

    // 4-beat burst with lanes equal to beat index, plus first-header latency.
    beats.delete();
    lens.delete();
    lens.push_back(4);
    for (int j = 0; j < 4; j++) begin
      logic [15:0] lane;
      lane = 16'(j);
      beats.push_back(mk_beat({8{lane}}, 8'h3C, 48'h0000_0100_0000 + 48'(j), 32'hDEAD_BEEF));
    end
    push_frame();
    fork
      drive_frame();
      begin
        @(posedge ACLK);
        @(negedge ACLK);
        check("latency_before", 130'(M_AXIS_TVALID), 130'(0));
        @(negedge ACLK);
        check("latency_header", 130'({M_AXIS_TVALID, M_AXIS_TDATA[127:112]}),
              130'({1'b1, 16'hAA55}));
      end
    join
    wait_room(0);
    check_counters("first_frame");

    // One-cycle gap merges; two-cycle gap separates.
    ready_mode = 2;
    beats.delete();
    lens.delete();
    lens.push_back(3);
    lens.push_back(2);
    for (int j = 0; j < 5; j++) beats.push_back(mk_beat({4{$urandom}}, 8'h07, 48'(j), 32'h1));
    run_frame(1'b1);
    simple_frame(3, 8'h07);
    run_frame(1'b1);
    simple_frame(2, 8'h07);
    run_frame(1'b1);

    // Truncation and info change.
    simple_frame(70, 8'h44);
    run_frame(1'b1);
    simple_frame(5, 8'h50);
    beats[2][87:80] = 8'h51;
    run_frame(1'b1);
    wait_room(0);
    check_counters("directed");

    // Second full-size frame does not fit behind a stalled first one.
    ready_mode = 0;
    repeat (2) @(posedge ACLK);
    simple_frame(64, 8'h60);
    run_frame(1'b1);
    beats.delete();
    lens.delete();
    lens.push_back(64);
    lens.push_back(5);
    for (int j = 0; j < 69; j++) beats.push_back(mk_beat({4{$urandom}}, 8'h61, 48'(j), 32'h2));
    run_frame(1'b0);
    @(negedge ACLK);
    check("drop_count_stalled", 130'(DROP_COUNT), 130'(model_drops));
    pops_before = pops;
    ready_mode  = 1;
    wait_room(0);
    check("drop_phase_pops", 130'(pops - pops_before), 130'(66));
    check_counters("drop");

    flush_mid_frame(1'b0);
    flush_mid_frame(1'b1);

    // Checksum patterns.
    ready_mode = 2;
    beats.delete();
    lens.delete();
    lens.push_back(2);
    beats.push_back(mk_beat({8{16'h0001}}, 8'h70, 48'd5, 32'h3));
    beats.push_back(mk_beat({8{16'h00F0}}, 8'h70, 48'd6, 32'h3));
    run_frame(1'b1);
    beats.delete();
    lens.delete();
    lens.push_back(1);
    beats.push_back(mk_beat({16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1},
                            8'h71, 48'd9, 32'h4));
    run_frame(1'b1);

    for (int f = 0; f < 25; f++) begin
      wait_room(60);
      gen_random_frame();
      run_frame(1'b1);
    end
    wait_room(0);
    check_counters("final");
    check("final_idle_valid", 130'(M_AXIS_TVALID), 130'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
